// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between N_REQ requesters. A round-robin
//   scan picks one pending request, latches its operands and drives the ALU
//   from those registers. Multiply (ALUcon=4'b0011) holds the ALU for
//   MUL_CYCLES cycles; every other opcode holds it for one cycle. The result
//   is then registered and offered to the granted requester until consumed.
//
//   Optional feature: define ALU_ARB_LOCK_EN to add req_lock. A requester
//   whose lock bit is high when it is granted keeps top priority for the
//   next arbitration, so it can issue back-to-back atomic sequences.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (req_ready one-hot, IDLE only)
//   req_opA/opB/ALUcon     flattened per-requester operands and opcode
//   req_lock               (ALU_ARB_LOCK_EN only) hold priority after grant
//   rsp_valid / rsp_ready  response handshake (rsp_valid one-hot)
//   rsp_result, rsp_cout   registered ALU result and carry
//   busy                   high while an operation is in EXEC or RESP
//   alu_*                  connection to the shared ALU
module alu_share_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_opA,
  input  logic [N_REQ*DATA_W-1:0] req_opB,
  input  logic [N_REQ*4-1:0]      req_ALUcon,
`ifdef ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_cout,
  output logic                    busy,
  output logic [DATA_W-1:0]       alu_opA,
  output logic [DATA_W-1:0]       alu_opB,
  output logic [3:0]              alu_ALUcon,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_cout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   gnt_nxt;
  logic               gnt_found;
  logic [IDX_W:0]     scan_idx;
  logic [3:0]         sel_con;
  logic [DATA_W-1:0]  opa_p0, opb_p0;
  logic [3:0]         alucon_p0;
  logic               lock_p0;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_nxt   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(N_REQ))
        scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
      if (!gnt_found && req_valid[scan_idx[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_nxt   = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign sel_con = req_ALUcon[gnt_nxt*4 +: 4];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found)
      req_ready[gnt_nxt] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant/latch stage: operands captured on acceptance drive the ALU for the
  // whole EXEC window, so requesters may change their inputs freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      gnt        <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      opa_p0     <= '0;
      opb_p0     <= '0;
      alucon_p0  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt       <= gnt_nxt;
            opa_p0    <= req_opA[gnt_nxt*DATA_W +: DATA_W];
            opb_p0    <= req_opB[gnt_nxt*DATA_W +: DATA_W];
            alucon_p0 <= sel_con;
            cnt       <= (sel_con == 4'b0011) ? CNT_W'(MUL_CYCLES-1) : '0;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result     <= alu_result;
            rsp_cout       <= alu_cout;
            rsp_valid      <= '0;
            rsp_valid[gnt] <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            if (lock_p0)
              rr_ptr <= gnt;
            else
              rr_ptr <= (gnt == IDX_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset)
      lock_p0 <= 1'b0;
    else if (state == IDLE && gnt_found)
      lock_p0 <= req_lock[gnt_nxt];
  end
`else
  assign lock_p0 = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign alu_opA    = opa_p0;
  assign alu_opB    = opb_p0;
  assign alu_ALUcon = alucon_p0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter (N_REQ=2, DATA_W=32, MUL_CYCLES=4). A small
//   behavioural ALU is attached to the alu_* ports; expected responses are
//   queued when a request is accepted and popped when rsp_valid is seen.
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int MC = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_opA, req_opB;
  logic [N*4-1:0] req_ALUcon;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_cout;
  logic           busy;
  logic [W-1:0]   alu_opA, alu_opB;
  logic [3:0]     alu_ALUcon;
  logic [W-1:0]   alu_result;
  logic           alu_cout;

  alu_share_arbiter #(.N_REQ(N), .DATA_W(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_ALUcon(req_ALUcon),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_ALUcon(alu_ALUcon),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Reference ALU: {cout, result}
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] con);
    logic [W:0] r;
    case (con)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {1'b0, a} - {1'b0, b};
      4'b0011: r = {1'b0, a * b};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_cout, alu_result} = alu_ref(alu_opA, alu_opB, alu_ALUcon);

  typedef struct {
    int         g;
    logic [W:0] e;
  } sb_item_t;

  sb_item_t   sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [3:0]   op_c [N];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_opA[i*W +: W]  = op_a[i];
      req_opB[i*W +: W]  = op_b[i];
      req_ALUcon[i*4 +: 4] = op_c[i];
    end
  endtask

  // One transaction: present vmask, expect grant g, hold the response for
  // 'hold' cycles (non-granted rsp_ready bits asserted), then consume it.
  task automatic run_op(input logic [N-1:0] vmask, input int g, input int hold, input int lat);
    sb_item_t   it;
    int         cyc;
    logic [W-1:0] r0;
    drive_ops();
    req_valid = vmask;
    #1;
    check_eq("req_ready", 64'(req_ready), 64'(1 << g));
    it.g = g;
    it.e = alu_ref(op_a[g], op_b[g], op_c[g]);
    sb.push_back(it);
    step();
    req_valid = '0;
    req_opA   = {$urandom, $urandom};
    req_opB   = {$urandom, $urandom};
    check_eq("busy_exec", 64'(busy), 64'(1));
    check_eq("alu_opA", 64'(alu_opA), 64'(op_a[g]));
    check_eq("alu_ALUcon", 64'(alu_ALUcon), 64'(op_c[g]));
    cyc = 1;
    while (rsp_valid == '0 && cyc < 30) begin
      step();
      cyc++;
    end
    check_eq("latency", 64'(cyc), 64'(lat));
    r0 = rsp_result;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~N'(1 << g);
      step();
      check_eq("hold_valid", 64'(rsp_valid), 64'(1 << g));
      check_eq("hold_result", 64'(rsp_result), 64'(r0));
      check_eq("hold_busy", 64'(busy), 64'(1));
    end
    rsp_ready = '1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'(0), 64'(1));
    end else begin
      it = sb.pop_front();
      check_eq("rsp_valid", 64'(rsp_valid), 64'(1 << it.g));
      check_eq("rsp_result", 64'(rsp_result), 64'(it.e[W-1:0]));
      check_eq("rsp_cout", 64'(rsp_cout), 64'(it.e[W]));
    end
    step();
    rsp_ready = '0;
    check_eq("rsp_clear", 64'(rsp_valid), 64'(0));
    check_eq("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_lock   = '0;
    rsp_ready  = '0;
    req_opA    = '0;
    req_opB    = '0;
    req_ALUcon = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
    end

    // T1 reset held two cycles
    step();
    step();
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_alucon", 64'(alu_ALUcon), 64'(0));
    check_eq("rst_result", 64'(rsp_result), 64'(0));
    reset = 1'b0;
    step();

    // T2 req0 5+7
    op_a[0] = 32'd5; op_b[0] = 32'd7; op_c[0] = 4'b0000;
    run_op(2'b01, 0, 0, 2);

    // T3 req1 all-ones + 1 -> carry out
    op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'd1; op_c[1] = 4'b0000;
    run_op(2'b10, 1, 0, 2);

    // T4 both valid, rr_ptr back at 0: grants 0,1,0
    op_a[0] = 32'd100; op_b[0] = 32'd23; op_c[0] = 4'b0000;
    op_a[1] = 32'd10;  op_b[1] = 32'd20; op_c[1] = 4'b0001;
    run_op(2'b11, 0, 0, 2);
    run_op(2'b11, 1, 1, 2);
    op_a[0] = 32'h8000_0000; op_b[0] = 32'h8000_0001;
    run_op(2'b11, 0, 0, 2);

    // T5 multiply 3*4, response held three cycles
    op_a[0] = 32'd3; op_b[0] = 32'd4; op_c[0] = 4'b0011;
    run_op(2'b01, 0, 3, MC + 1);

    // Unsupported opcode passes through, ALU returns 0
    op_a[1] = 32'd9; op_b[1] = 32'd9; op_c[1] = 4'b1111;
    run_op(2'b10, 1, 0, 2);

    // T6 reset during cycle 2 of a multiply
    op_a[1] = 32'd6; op_b[1] = 32'd7; op_c[1] = 4'b0011;
    drive_ops();
    req_valid = 2'b10;
    #1;
    check_eq("t6_ready", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_busy", 64'(busy), 64'(0));
    check_eq("t6_alucon", 64'(alu_ALUcon), 64'(0));
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t6_no_rsp", 64'(rsp_valid), 64'(0));
    end
    op_a[1] = 32'd40; op_b[1] = 32'd2; op_c[1] = 4'b0000;
    run_op(2'b10, 1, 0, 2);

    check_eq("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
